// File: rtl/serial_frame_rx.sv
// Serial frame receiver: header, command bit, payload, tail, with a one-entry valid/ready output buffer.
// Define SERIAL_FRAME_RX_PARITY_EN to insert an even-parity bit between payload and tail.
module serial_frame_rx #(
  parameter int                  HDR_LEN  = 4,
  parameter logic [HDR_LEN-1:0]  HDR_PAT  = 4'b0101,
  parameter int                  DATA_W   = 8,
  parameter int                  TAIL_LEN = 4,
  parameter logic [TAIL_LEN-1:0] TAIL_PAT = 4'b1010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              data_in,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic              frm_cmd,
  output logic [DATA_W-1:0] frm_data,
  output logic              err,
  output logic              ovf
);

  localparam int MAX_LEN = (HDR_LEN > DATA_W)
                         ? ((HDR_LEN > TAIL_LEN) ? HDR_LEN : TAIL_LEN)
                         : ((DATA_W > TAIL_LEN) ? DATA_W : TAIL_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_LIM = 1 << CNT_W;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, HDR, CMD, PAY, PAR, TAIL} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, CMD, PAY, TAIL} state_t;
`endif

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                cmd_reg, cmd_next;
  logic                frame_done, frame_bad;

  logic                frm_valid_reg, frm_valid_next;
  logic                frm_cmd_reg, frm_cmd_next;
  logic [DATA_W-1:0]   frm_data_reg, frm_data_next;
  logic                err_reg, err_next;
  logic                ovf_reg, ovf_next;

  // Patterns re-ordered so the expected bit is indexed directly by the bit counter.
  logic [CNT_LIM-1:0]  hdr_exp, tail_exp;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_LIM; gi++) begin : g_pat
      if (gi < HDR_LEN) begin : g_hdr
        assign hdr_exp[gi] = HDR_PAT[HDR_LEN-1-gi];
      end else begin : g_hdr_pad
        assign hdr_exp[gi] = 1'b0;
      end
      if (gi < TAIL_LEN) begin : g_tail
        assign tail_exp[gi] = TAIL_PAT[TAIL_LEN-1-gi];
      end else begin : g_tail_pad
        assign tail_exp[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      cmd_reg       <= 1'b0;
      frm_valid_reg <= 1'b0;
      frm_cmd_reg   <= 1'b0;
      frm_data_reg  <= '0;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      cmd_reg       <= cmd_next;
      frm_valid_reg <= frm_valid_next;
      frm_cmd_reg   <= frm_cmd_next;
      frm_data_reg  <= frm_data_next;
      err_reg       <= err_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    cmd_next   = cmd_reg;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (en) begin
      unique case (state_reg)
        IDLE: begin
          if (data_in == hdr_exp[0]) begin
            state_next = HDR;
            cnt_next   = CNT_W'(1);
          end
        end
        HDR: begin
          // A mismatch drops straight back to IDLE without trying to re-align.
          if (data_in != hdr_exp[cnt_reg]) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == HDR_LAST) begin
            state_next = CMD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        CMD: begin
          cmd_next   = data_in;
          state_next = PAY;
          cnt_next   = '0;
        end
        PAY: begin
          shift_next = DATA_W'({shift_reg, data_in});
          if (cnt_reg == DATA_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_next = PAR;
`else
            state_next = TAIL;
`endif
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PAR: begin
          cnt_next = '0;
          if (cmd_reg ^ (^shift_reg) ^ data_in) begin
            frame_bad  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = TAIL;
          end
        end
`endif
        TAIL: begin
          if (data_in != tail_exp[cnt_reg]) begin
            frame_bad  = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == TAIL_LAST) begin
            frame_done = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    frm_valid_next = frm_valid_reg;
    frm_cmd_next   = frm_cmd_reg;
    frm_data_next  = frm_data_reg;
    err_next       = frame_bad;
    ovf_next       = 1'b0;
    if (frm_valid_reg && frm_ready) begin
      frm_valid_next = 1'b0;
    end
    // A frame completing while the buffer is being drained replaces it in the same edge.
    if (frame_done) begin
      if (!frm_valid_reg || frm_ready) begin
        frm_valid_next = 1'b1;
        frm_cmd_next   = cmd_reg;
        frm_data_next  = shift_reg;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  assign frm_valid = frm_valid_reg;
  assign frm_cmd   = frm_cmd_reg;
  assign frm_data  = frm_data_reg;
  assign err       = err_reg;
  assign ovf       = ovf_reg;

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Parametrised serial frame receiver. Successor to the fixed 4-bit header/command/payload/tail packet receiver.
- Runtime behaviour: bit-enable stall, configurable header and tail patterns, configurable payload width, error reporting, and a one-entry valid/ready output buffer.
- Sits between a serial line sampler (one bit per enabled cycle) and a parallel consumer.

Parameters:
- HDR_LEN, 4, header length in bits (2..16)
- HDR_PAT, 4'b0101, header pattern; MSB received first
- DATA_W, 8, payload width in bits (1..32)
- TAIL_LEN, 4, tail length in bits (1..16)
- TAIL_PAT, 4'b1010, tail pattern; MSB received first

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  bit strobe; data_in is consumed only in cycles where en=1
- data_in  input  1  serial bit
- frm_valid  output  1  frame buffer holds an unread frame
- frm_ready  input  1  consumer accepts the frame when frm_valid & frm_ready
- frm_cmd  output  1  command bit of the buffered frame
- frm_data  output  DATA_W  payload of the buffered frame; first received bit lands in MSB
- err  output  1  one-cycle pulse when a tail mismatch occurs
- ovf  output  1  one-cycle pulse when a completed frame is dropped because the buffer is full

Behaviour:
- Reset (asynchronous, while rst=1):
  - State is IDLE; bit counter is 0; shift register is 0.
  - frm_valid, frm_cmd, frm_data, err and ovf are all 0.
- Bit rule: a "bit" is a cycle with en=1. Cycles with en=0 leave state, counter and shift register unchanged, in every state.
- States: IDLE, HDR, CMD, PAY, TAIL. Bit counter is wide enough for max(HDR_LEN, DATA_W, TAIL_LEN).
- IDLE:
  - Bit equal to HDR_PAT[HDR_LEN-1] -> HDR with cnt=1.
  - Any other bit is discarded.
- HDR:
  - Bit equal to HDR_PAT[HDR_LEN-1-cnt] -> cnt+1.
  - When cnt reaches HDR_LEN -> CMD, cnt=0.
  - Mismatch -> IDLE. The mismatching bit is discarded; there is no overlap re-match and no err.
- CMD: next bit is latched as the command bit -> PAY, cnt=0.
- PAY:
  - Each bit shifts into the shift register from the LSB side.
  - After DATA_W bits -> TAIL, cnt=0.
- TAIL:
  - Bit equal to TAIL_PAT[TAIL_LEN-1-cnt] -> cnt+1.
  - After TAIL_LEN matching bits the frame is complete -> IDLE.
  - Mismatch -> err=1 for the following cycle, frame discarded, -> IDLE.
- Frame completion: the shift register and command bit transfer to the output buffer on the completing edge. frm_valid rises one cycle after the last tail bit is sampled.
- Output handshake:
  - frm_valid, frm_cmd and frm_data are registered and held stable until frm_valid & frm_ready.
  - After acceptance, frm_valid falls on the next edge unless a new frame completes on that edge.
  - The consumer may hold frm_ready high permanently.
- Buffer full (frm_valid=1, frm_ready=0) at completion:
  - The new frame is dropped and ovf pulses for one cycle.
  - The buffer keeps the old frame.
- Simultaneous completion and acceptance: the new frame loads into the buffer, frm_valid stays 1, no ovf.
- Back-to-back frames: the receiver re-arms in IDLE immediately after the tail, with no dead cycle.
- err and ovf are registered single-cycle pulses; both can assert in the same cycle only in different frames, which is impossible, so they are mutually exclusive.
- Reset asserted mid-frame: the partial frame is lost and the buffered frame is lost.

Optional Feature:
- SERIAL_FRAME_RX_PARITY_EN defined:
  - A parity bit follows the payload (new PAR state between PAY and TAIL).
  - Expected value: even parity over {cmd, payload}, i.e. the XOR of cmd, all payload bits and the parity bit equals 0.
  - Mismatch -> err pulse, frame discarded, -> IDLE (tail not waited for).
- Not defined: no PAR state; PAY proceeds directly to TAIL. Timing is exactly as above.

Test Plan:
- Defaults, en=1 continuously, bits 0101 1 10110011 1010, frm_ready=1 -> frm_valid pulses 1 cycle after the last tail bit with frm_cmd=1, frm_data=8'hB3; err=0.
- Same frame with en toggling 1/0 every cycle -> identical frm_cmd/frm_data; completion delayed to 2x the bit count; no err.
- Header 0100 followed by a valid frame -> first attempt abandoned silently; second frame delivered with frm_data matching; err=0.
- Valid header, cmd 0, payload 8'h5A, tail 1011 -> err=1 for exactly one cycle; frm_valid stays 0.
- Two valid frames (8'h11 then 8'h22) with frm_ready=0 throughout -> frm_data=8'h11 held; ovf=1 one cycle at the second completion. Raising frm_ready then drops frm_valid on the next edge.
- rst=1 pulsed mid-payload, then a full valid frame with payload 8'hC3 -> outputs 0 during reset; the following frame is received correctly with frm_data=8'hC3. With PARITY_EN, a wrong parity bit -> err pulse, no frm_valid.
